// File: rtl/par_to_ser_stream.sv
// Parallel-to-serial converter with valid/ready on both sides: one WIDTH-bit word in,
// one bit per transfer out, with backpressure, no-bubble back-to-back words and abort.
module par_to_ser_stream #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             ser_last,
    output logic [CNT_W-1:0] word_count
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]   word_count_q, word_count_d;

    logic xfer;
    logic last_xfer;
    logic accept;
    logic [WIDTH-1:0] shreg_shifted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            word_count_q <= word_count_d;
        end
    end

    always_comb begin
        ser_valid     = (state_q == SHIFT);
        ser_last      = ser_valid && (bit_idx_q == LAST_IDX);
        ser_out       = ser_valid ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : 1'b0;
        xfer          = ser_valid && ser_ready;
        last_xfer     = xfer && (bit_idx_q == LAST_IDX);
        // Gating with abort keeps an aborted cycle from swallowing an upstream word.
        in_ready      = !rst && !abort && ((state_q == IDLE) || last_xfer);
        accept        = in_valid && in_ready;
        shreg_shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_idx_d    = bit_idx_q;
        word_count_d = word_count_q;

        if (abort) begin
            state_d   = IDLE;
            bit_idx_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg_d   = in_data;
                        bit_idx_d = '0;
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_xfer) begin
                        word_count_d = word_count_q + CNT_W'(1);
                        if (accept) begin
                            shreg_d   = in_data;
                            bit_idx_d = '0;
                        end else begin
                            shreg_d   = shreg_shifted;
                            bit_idx_d = '0;
                            state_d   = IDLE;
                        end
                    end else if (xfer) begin
                        shreg_d   = shreg_shifted;
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign word_count = word_count_q;

endmodule

// File: tb/tb_par_to_ser_stream.sv
// Directed bench for par_to_ser_stream: three instances (LSB-first, MSB-first, 2-bit counter)
// share one stimulus stream; a vector table drives it, hand sequences cover reset.
module tb_par_to_ser_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       abort;
    logic       ser_ready;

    logic       in_ready,   ser_valid,   ser_out,   ser_last;
    logic       in_ready_m, ser_valid_m, ser_out_m, ser_last_m;
    logic       in_ready_c, ser_valid_c, ser_out_c, ser_last_c;
    logic [7:0] word_count, word_count_m;
    logic [1:0] word_count_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    par_to_ser_stream #(.WIDTH(4), .MSB_FIRST(1'b0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .abort(abort), .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_out(ser_out),
        .ser_last(ser_last), .word_count(word_count)
    );

    par_to_ser_stream #(.WIDTH(4), .MSB_FIRST(1'b1), .CNT_W(8)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
        .abort(abort), .ser_valid(ser_valid_m), .ser_ready(ser_ready), .ser_out(ser_out_m),
        .ser_last(ser_last_m), .word_count(word_count_m)
    );

    par_to_ser_stream #(.WIDTH(4), .MSB_FIRST(1'b0), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
        .abort(abort), .ser_valid(ser_valid_c), .ser_ready(ser_ready), .ser_out(ser_out_c),
        .ser_last(ser_last_c), .word_count(word_count_c)
    );

    typedef struct {
        logic       iv;
        logic [3:0] d;
        logic       rdy;
        logic       ab;
        logic       sv;
        logic       so;
        logic       sl;
        logic       ir;
        logic       mo;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [3:0] d, input logic rdy, input logic ab,
                       input logic sv, input logic so, input logic sl, input logic ir,
                       input logic mo, input logic [7:0] cnt);
        vec_t v;
        v.iv = iv; v.d = d; v.rdy = rdy; v.ab = ab;
        v.sv = sv; v.so = so; v.sl = sl; v.ir = ir; v.mo = mo; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; abort = 1'b0; ser_ready = 1'b1;

        // iv d rdy ab | sv so sl ir mo cnt
        // 4'b1011, LSB 1,1,0,1 / MSB 1,0,1,1
        add(1, 4'hB, 1, 0,  0, 0, 0, 1, 0, 0);
        add(0, 4'h0, 1, 0,  1, 1, 0, 0, 1, 0);
        add(0, 4'h0, 1, 0,  1, 1, 0, 0, 0, 0);
        add(0, 4'h0, 1, 0,  1, 0, 0, 0, 1, 0);
        add(0, 4'h0, 1, 0,  1, 1, 1, 1, 1, 0);
        add(0, 4'h0, 1, 0,  0, 0, 0, 1, 0, 1);
        // 4'b0110 with a 3-cycle stall after bit 1; in_valid offered during stall is ignored
        add(1, 4'h6, 1, 0,  0, 0, 0, 1, 0, 1);
        add(0, 4'h0, 1, 0,  1, 0, 0, 0, 0, 1);
        add(0, 4'h0, 1, 0,  1, 1, 0, 0, 1, 1);
        add(1, 4'h9, 0, 0,  1, 1, 0, 0, 1, 1);
        add(1, 4'h9, 0, 0,  1, 1, 0, 0, 1, 1);
        add(1, 4'h9, 0, 0,  1, 1, 0, 0, 1, 1);
        add(0, 4'h0, 1, 0,  1, 1, 0, 0, 1, 1);
        add(0, 4'h0, 1, 0,  1, 0, 1, 1, 0, 1);
        add(0, 4'h0, 1, 0,  0, 0, 0, 1, 0, 2);
        // back-to-back 4'hA then 4'h5
        add(1, 4'hA, 1, 0,  0, 0, 0, 1, 0, 2);
        add(1, 4'h5, 1, 0,  1, 0, 0, 0, 1, 2);
        add(1, 4'h5, 1, 0,  1, 1, 0, 0, 0, 2);
        add(1, 4'h5, 1, 0,  1, 0, 0, 0, 1, 2);
        add(1, 4'h5, 1, 0,  1, 1, 1, 1, 0, 2);
        add(0, 4'h0, 1, 0,  1, 1, 0, 0, 0, 3);
        add(0, 4'h0, 1, 0,  1, 0, 0, 0, 1, 3);
        add(0, 4'h0, 1, 0,  1, 1, 0, 0, 0, 3);
        add(0, 4'h0, 1, 0,  1, 0, 1, 1, 1, 3);
        add(0, 4'h0, 1, 0,  0, 0, 0, 1, 0, 4);
        // abort on bit 2 of 4'hF (with in_valid high), then 4'h3
        add(1, 4'hF, 1, 0,  0, 0, 0, 1, 0, 4);
        add(0, 4'h0, 1, 0,  1, 1, 0, 0, 1, 4);
        add(0, 4'h0, 1, 0,  1, 1, 0, 0, 1, 4);
        add(1, 4'hC, 1, 1,  1, 1, 0, 0, 1, 4);
        add(0, 4'h0, 1, 0,  0, 0, 0, 1, 0, 4);
        add(1, 4'h3, 1, 0,  0, 0, 0, 1, 0, 4);
        add(0, 4'h0, 1, 0,  1, 1, 0, 0, 0, 4);
        add(0, 4'h0, 1, 0,  1, 1, 0, 0, 0, 4);
        add(0, 4'h0, 1, 0,  1, 0, 0, 0, 1, 4);
        add(0, 4'h0, 1, 0,  1, 0, 1, 1, 1, 4);
        add(0, 4'h0, 1, 0,  0, 0, 0, 1, 0, 5);
        // abort coinciding with the last bit of 4'h8: no count, no accept
        add(1, 4'h8, 1, 0,  0, 0, 0, 1, 0, 5);
        add(0, 4'h0, 1, 0,  1, 0, 0, 0, 1, 5);
        add(0, 4'h0, 1, 0,  1, 0, 0, 0, 0, 5);
        add(0, 4'h0, 1, 0,  1, 0, 0, 0, 0, 5);
        add(1, 4'h2, 1, 1,  1, 1, 1, 0, 0, 5);
        add(0, 4'h0, 1, 0,  0, 0, 0, 1, 0, 5);
        // abort while idle
        add(1, 4'h7, 1, 1,  0, 0, 0, 0, 0, 5);
        add(0, 4'h0, 1, 0,  0, 0, 0, 1, 0, 5);

        // reset state while rst is held
        step();
        check("reset ser_valid", ser_valid, 0);
        check("reset ser_out", ser_out, 0);
        check("reset ser_last", ser_last, 0);
        check("reset in_ready", in_ready, 0);
        check("reset word_count", word_count, 0);
        step();
        rst = 1'b0;
        #1;
        check("post-reset in_ready", in_ready, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            ser_ready = vecs[i].rdy;
            abort     = vecs[i].ab;
            #1;
            check($sformatf("v%0d ser_valid", i), ser_valid, vecs[i].sv);
            check($sformatf("v%0d ser_out", i), ser_out, vecs[i].so);
            check($sformatf("v%0d ser_last", i), ser_last, vecs[i].sl);
            check($sformatf("v%0d in_ready", i), in_ready, vecs[i].ir);
            check($sformatf("v%0d word_count", i), word_count, vecs[i].cnt);
            check($sformatf("v%0d msb ser_out", i), ser_out_m, vecs[i].mo);
            check($sformatf("v%0d msb ser_last", i), ser_last_m, vecs[i].sl);
            check($sformatf("v%0d wrap word_count", i), word_count_c, vecs[i].cnt[1:0]);
            $display("vec %0d: iv=%0b d=%h rdy=%0b ab=%0b -> sv=%0b so=%0b sl=%0b ir=%0b mo=%0b cnt=%0d cnt2=%0d",
                     i, in_valid, in_data, ser_ready, abort, ser_valid, ser_out, ser_last,
                     in_ready, ser_out_m, word_count, word_count_c);
            @(posedge clk);
            #1;
        end

        // asynchronous reset in the middle of 4'hB, between clock edges
        in_valid = 1'b1; in_data = 4'hB; abort = 1'b0; ser_ready = 1'b1;
        #1;
        check("mid-reset accept ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        step();
        #1;
        check("mid-reset pre ser_out", ser_out, 1);
        check("mid-reset pre ser_valid", ser_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        check("async reset ser_valid", ser_valid, 0);
        check("async reset ser_out", ser_out, 0);
        check("async reset in_ready", in_ready, 0);
        check("async reset word_count", word_count, 0);
        check("async reset wrap word_count", word_count_c, 0);
        $display("async reset: sv=%0b so=%0b ir=%0b cnt=%0d", ser_valid, ser_out, in_ready, word_count);
        rst = 1'b0;
        #1;
        check("after reset in_ready", in_ready, 1);
        step();
        check("after reset idle ser_valid", ser_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/par_to_ser_stream.md
Name: par_to_ser_stream

Overview:
- Parametrised parallel-to-serial converter with valid/ready handshakes on both sides.
- Accepts one WIDTH-bit word and emits it one bit per transfer, LSB-first or MSB-first.
- Supports downstream backpressure, back-to-back words with no bubble, synchronous abort, and a count of completed words.
- Replaces the fixed 4-bit, load-strobe, free-rotating converter in serial-link datapaths.

Parameters:
- WIDTH, 4, bits per word; must be >= 2.
- MSB_FIRST, 0, 0 = bit 0 sent first; 1 = bit WIDTH-1 sent first.
- CNT_W, 8, width of the completed-word counter; the counter wraps.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is offered.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  parallel word; sampled only on accept.
- abort  in  1  synchronous; drops the current word.
- ser_valid  out  1  ser_out holds a valid bit.
- ser_ready  in  1  downstream takes the bit this cycle.
- ser_out  out  1  current serial bit.
- ser_last  out  1  current bit is the final bit of the word.
- word_count  out  CNT_W  number of fully transmitted words, mod 2^CNT_W.

Behaviour:
- State: IDLE or SHIFT. Also holds shreg[WIDTH-1:0], bit_idx[$clog2(WIDTH)-1:0] and word_count.
- Reset (async assert; takes effect immediately):
  - state = IDLE; shreg = 0; bit_idx = 0; word_count = 0.
  - Outputs: ser_valid = 0, ser_out = 0, ser_last = 0.
  - in_ready = 0 while rst is high, and 1 from the first cycle after deassertion.
- Definitions:
  - xfer = ser_valid & ser_ready.
  - last_xfer = xfer & (bit_idx == WIDTH-1).
  - accept = in_valid & in_ready.
- Combinational outputs:
  - in_ready = !rst & !abort & (state == IDLE | last_xfer).
  - ser_valid = (state == SHIFT).
  - ser_out = ser_valid ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : 0.
  - ser_last = ser_valid & (bit_idx == WIDTH-1).
- IDLE + accept:
  - shreg <= in_data; bit_idx <= 0; state <= SHIFT.
  - The first bit is visible in the cycle after the accept edge (1-cycle latency).
- SHIFT + xfer, not last:
  - LSB-first: shreg <= shreg >> 1. MSB-first: shreg <= shreg << 1. Zero fill in both cases.
  - bit_idx <= bit_idx + 1.
- SHIFT + last_xfer:
  - word_count <= word_count + 1, wrapping at 2^CNT_W.
  - If accept in the same cycle: load the new word, bit_idx <= 0, stay in SHIFT. No bubble, so throughput is 1 word per WIDTH cycles.
  - Otherwise: state <= IDLE.
- SHIFT with ser_ready = 0:
  - shreg, bit_idx and ser_out hold; ser_valid stays 1. Ready-independent valid is required.
  - in_data must not be captured.
- Abort (abort = 1 at an edge) has priority over xfer and accept:
  - state <= IDLE; bit_idx <= 0; shreg unchanged.
  - word_count is not incremented, even if the last bit transfers that cycle.
  - in_ready = 0 in that cycle, so no word is lost on the input side.
- Abort in IDLE: no effect.
- in_valid while in_ready = 0: ignored. The upstream holds in_data stable until accepted.
- Reset asserted mid-word: the word is discarded and state returns to reset values immediately.

Test Plan:
- WIDTH=4, MSB_FIRST=0, ser_ready=1, accept 4'b1011:
  - ser_out = 1,1,0,1 over 4 cycles starting the cycle after accept.
  - ser_last high on the 4th bit only; word_count 0 -> 1; then IDLE with in_ready = 1.
- Same stimulus with MSB_FIRST=1: ser_out = 1,0,1,1.
- Backpressure: ser_ready low for 3 cycles after bit 1 of 4'b0110 (LSB-first):
  - ser_out holds 1 and ser_valid stays 1 during the stall.
  - Full sequence is 0,1,1,0 with no bit lost or duplicated.
- Back-to-back: in_valid held high with 4'hA then 4'h5, ser_ready=1:
  - 8 consecutive valid bits 0,1,0,1,1,0,1,0.
  - in_ready pulses in the cycle of the 4th bit of the first word; word_count = 2.
- Abort on bit 2 of 4'hF:
  - ser_valid = 0 next cycle; word_count unchanged.
  - A new word 4'h3 is accepted afterwards and serialises correctly as 1,1,0,0.
- Async reset mid-word, plus counter wrap:
  - rst pulsed between edges mid-word: ser_valid and ser_out drop immediately; word_count = 0.
  - With CNT_W=2, send 5 words: word_count = 1.
